// File: rtl/servo.sv
// Hobby-servo PWM exerciser.
// Emits one pulse per frame and sweeps the pulse width up and down in a
// triangle between MIN_PULSE and MAX_PULSE, moving by STEP once per frame.
// The pin is driven straight from a flop, so there is no combinational glitch path.
module servo #(
  parameter int PERIOD_CYCLES = 2_000_000,
  parameter int MIN_PULSE     = 100_000,
  parameter int MAX_PULSE     = 200_000,
  parameter int STEP          = 10_000
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic pwm_out
);

  // Counter width covers 0..PERIOD_CYCLES-1.
  // The width register shares this width because MAX_PULSE < PERIOD_CYCLES.
  localparam int CW = $clog2(PERIOD_CYCLES);

  // Constants sized to the datapath.
  // The *_X forms carry one extra bit, so w + STEP and MIN_PULSE + STEP cannot wrap.
  localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] MIN_W    = CW'(MIN_PULSE);
  localparam logic [CW-1:0] MAX_W    = CW'(MAX_PULSE);
  localparam logic [CW:0]   MIN_X    = (CW+1)'(MIN_PULSE);
  localparam logic [CW:0]   MAX_X    = (CW+1)'(MAX_PULSE);
  localparam logic [CW:0]   STEP_X   = (CW+1)'(STEP);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] w_q, w_d;
  logic          up_q, up_d;
  logic          pwm_q, pwm_d;

  logic          wrap;
  logic [CW:0]   w_x;
  logic [CW:0]   w_plus;
  logic [CW:0]   w_minus;
  logic [CW:0]   low_limit;

  // Shared frame-boundary flag and widened arithmetic for the sweep update.
  always_comb begin
    wrap      = (cnt_q == LAST_CNT);
    w_x       = {1'b0, w_q};
    w_plus    = w_x + STEP_X;
    w_minus   = w_x - STEP_X;
    low_limit = MIN_X + STEP_X;
  end

  // Frame counter: free-runs and wraps back to zero at the end of each frame.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (wrap) begin
      cnt_d = '0;
    end
  end

  // Sweep update.
  // The width and direction change only at the frame boundary, so a pulse already in flight keeps its length.
  // Both ends are clamped, so a STEP that does not divide the range evenly still lands exactly on MIN/MAX.
  always_comb begin
    w_d  = w_q;
    up_d = up_q;
    if (wrap) begin
      if (up_q) begin
        if (w_plus >= MAX_X) begin
          w_d  = MAX_W;
          up_d = 1'b0;
        end else begin
          w_d = w_plus[CW-1:0];
        end
      end else begin
        if (w_x <= low_limit) begin
          w_d  = MIN_W;
          up_d = 1'b1;
        end else begin
          w_d = w_minus[CW-1:0];
        end
      end
    end
  end

  // Output compare on the pre-increment count.
  // The registered pin therefore trails the counter by one cycle.
  always_comb begin
    pwm_d = (cnt_q < w_q);
  end

  // State registers.
  // Reset restarts the sweep at the narrowest pulse heading upward and forces the pin low immediately.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      w_q   <= MIN_W;
      up_q  <= 1'b1;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      w_q   <= w_d;
      up_q  <= up_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_servo.sv
// Scoreboard bench for servo using shrunk frame parameters.
// Instance A sweeps 10..30 in steps of 10.
// Instance B sweeps 10..25 in steps of 10, so the step does not divide the range and both ends are clamped.
// Expected pulse widths are queued as stimulus is issued.
// Per-instance monitors measure every completed pulse, pop the queue and compare.
// The monitors also check the rising-edge spacing.
module tb_servo;

  localparam int PERIOD = 100;

  logic clk;
  logic rst_a, rst_b;
  logic pwm_a, pwm_b;

  int vectors;
  int miscompares;
  int cyc;

  int exp_a[$];
  int exp_b[$];

  servo #(.PERIOD_CYCLES(PERIOD), .MIN_PULSE(10), .MAX_PULSE(30), .STEP(10)) dut_a (
    .clk_in (clk),
    .rst_in (rst_a),
    .pwm_out(pwm_a)
  );

  servo #(.PERIOD_CYCLES(PERIOD), .MIN_PULSE(10), .MAX_PULSE(25), .STEP(10)) dut_b (
    .clk_in (clk),
    .rst_in (rst_b),
    .pwm_out(pwm_b)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for measuring rising-edge spacing.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor for A: pops one expected width per completed pulse and checks the frame period.
  initial begin : mon_a
    int hi, last_rise;
    bit prev;
    hi = 0; last_rise = -1; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        hi = 0; last_rise = -1;
        prev = 1'b0;
      end else begin
        if (pwm_a && !prev) begin
          if (last_rise >= 0) checkOutput("periodA", cyc - last_rise, PERIOD);
          last_rise = cyc;
          hi = 0;
        end
        if (pwm_a) hi++;
        if (!pwm_a && prev) begin
          if (exp_a.size() == 0) checkOutput("unexpectedPulseA", hi, 0);
          else checkOutput("widthA", hi, exp_a.pop_front());
        end
        prev = pwm_a;
      end
    end
  end

  // Monitor for B, same scheme.
  initial begin : mon_b
    int hi, last_rise;
    bit prev;
    hi = 0; last_rise = -1; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        hi = 0; last_rise = -1;
        prev = 1'b0;
      end else begin
        if (pwm_b && !prev) begin
          if (last_rise >= 0) checkOutput("periodB", cyc - last_rise, PERIOD);
          last_rise = cyc;
          hi = 0;
        end
        if (pwm_b) hi++;
        if (!pwm_b && prev) begin
          if (exp_b.size() == 0) checkOutput("unexpectedPulseB", hi, 0);
          else checkOutput("widthB", hi, exp_b.pop_front());
        end
        prev = pwm_b;
      end
    end
  end

  // Issues a two-cycle reset on A while A may be mid-pulse.
  // Checks the pin is low the cycle after reset is sampled, queues the restarted sweep,
  // and checks the first post-reset cycle is high.
  task automatic applyStimulus(input string tag);
    rst_a = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "PwmLowInReset"}, int'(pwm_a), 0);
    @(posedge clk); #1;
    checkOutput({tag, "PwmStillLow"}, int'(pwm_a), 0);
    exp_a.push_back(10);
    exp_a.push_back(20);
    exp_a.push_back(30);
    exp_a.push_back(20);
    rst_a = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, "FirstCycleHigh"}, int'(pwm_a), 1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Power-on reset of both instances.
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("resetPwmA", int'(pwm_a), 0);
    checkOutput("resetPwmB", int'(pwm_b), 0);

    // Triangle sweeps.
    // A: 10,20,30,20,10,20,30 (each extreme held for a single frame).
    // B: 10,20,25,15,10,20 (clamped at both ends).
    exp_a.push_back(10); exp_a.push_back(20); exp_a.push_back(30);
    exp_a.push_back(20); exp_a.push_back(10); exp_a.push_back(20);
    exp_a.push_back(30);
    exp_b.push_back(10); exp_b.push_back(20); exp_b.push_back(25);
    exp_b.push_back(15); exp_b.push_back(10); exp_b.push_back(20);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;
    checkOutput("firstHighA", int'(pwm_a), 1);
    checkOutput("firstHighB", int'(pwm_b), 1);

    fork
      begin : seq_b
        // Park B in reset once its sweep is verified, before its next pulse starts.
        int n;
        n = 0;
        while (exp_b.size() != 0 && n < 2000) begin
          @(posedge clk); #1;
          n++;
        end
        if (exp_b.size() != 0) checkOutput("drainTimeoutB", exp_b.size(), 0);
        rst_b = 1'b1;
      end
      begin : seq_a
        int n;
        n = 0;
        while (exp_a.size() != 0 && n < 2000) begin
          @(posedge clk); #1;
          n++;
        end
        if (exp_a.size() != 0) checkOutput("drainTimeoutA", exp_a.size(), 0);

        // Wait for the next pulse to start, then reset five cycles into it.
        n = 0;
        while (!pwm_a && n < 300) begin
          @(posedge clk); #1;
          n++;
        end
        if (!pwm_a) checkOutput("riseTimeoutA", int'(pwm_a), 1);
        repeat (5) @(posedge clk);
        #1;
        applyStimulus("midPulse");

        n = 0;
        while (exp_a.size() != 0 && n < 2000) begin
          @(posedge clk); #1;
          n++;
        end
        if (exp_a.size() != 0) checkOutput("drainTimeoutA2", exp_a.size(), 0);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
